// File: rtl/reg_readout_pkg.sv
// Shared types and helpers for the reg_readout word-to-beat serializer.
package reg_readout_pkg;

  // Controller states: no word held, or a word held with beats still pending.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of the beat index counter; one bit minimum so a single-beat word
  // still has a legal counter.
  function automatic int idx_width(input int width, input int slice);
    int n;
    n = width / slice;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_readout.sv
// reg_readout: loads a WIDTH-bit word in one parallel capture and drains it as
// SLICE-bit beats, LSB slice first, over a valid/ready handshake. load_ready
// looks at out_ready combinationally so a new word can follow the last beat
// of the previous one without a bubble.
// Optional build macro: REG_READOUT_PARITY_EN adds out_parity, the even
// parity (XOR reduction) of out_data, registered alongside it.
module reg_readout
  import reg_readout_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SLICE-1:0] out_data,
  output logic             out_last
`ifdef REG_READOUT_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int NUM_SLICES = WIDTH / SLICE;
  localparam int IDX_W      = idx_width(WIDTH, SLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("reg_readout: WIDTH must be a multiple of SLICE");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shift_p0;
  logic [WIDTH-1:0] shift_next;
  logic [IDX_W-1:0] idx_p0;
  logic [IDX_W-1:0] idx_next;
  logic [SLICE-1:0] data_next;
  logic             vld_next;
  logic             last_next;
  logic             load_fire;
  logic             beat_fire;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: leave SHIFT only when the last beat drains with no new
  // word arriving on the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_fire) state_next = SHIFT;
      SHIFT:   if (beat_fire && out_last && !load_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs and fire strobes.
  always_comb begin
    load_ready = (state == IDLE) || ((state == SHIFT) && out_last && out_ready);
    load_fire  = load_valid && load_ready;
    beat_fire  = out_valid && out_ready;
  end

  // Next beat selection: a load restarts at slice 0, a non-final beat
  // advances the index, the final beat without a load clears the output.
  always_comb begin
    shift_next = shift_p0;
    idx_next   = idx_p0;
    vld_next   = out_valid;
    data_next  = out_data;
    last_next  = out_last;
    if (load_fire) begin
      shift_next = load_data;
      idx_next   = '0;
      vld_next   = 1'b1;
      data_next  = load_data[SLICE-1:0];
      last_next  = (NUM_SLICES == 1);
    end else if (beat_fire) begin
      if (out_last) begin
        idx_next  = '0;
        vld_next  = 1'b0;
        data_next = '0;
        last_next = 1'b0;
      end else begin
        idx_next  = idx_p0 + IDX_W'(1);
        data_next = SLICE'(shift_p0 >> (SLICE * int'(idx_next)));
        last_next = (idx_next == LAST_IDX);
      end
    end
  end

  // Parallel capture and registered beat outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_p0  <= '0;
      idx_p0    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      shift_p0  <= shift_next;
      idx_p0    <= idx_next;
      out_valid <= vld_next;
      out_data  <= data_next;
      out_last  <= last_next;
    end
  end

`ifdef REG_READOUT_PARITY_EN
  // Even parity of the beat, zero whenever no beat is valid (data is zero then).
  always_ff @(posedge clk) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else begin
      out_parity <= ^data_next;
    end
  end
`endif

endmodule

// File: tb/tb_reg_readout.sv
// Directed bench for reg_readout: a per-cycle vector table for the 32/8
// configuration plus hand sequences for the single-beat (8/8) configuration
// and, when REG_READOUT_PARITY_EN is defined, the parity output.
module tb_reg_readout;

  logic        clk = 1'b0;
  logic        rst;
  logic        lv;
  logic [31:0] ld;
  logic        ordy;
  logic        ov;
  logic [7:0]  od;
  logic        ol;
  logic        lr;

  logic        lv8;
  logic [7:0]  ld8;
  logic        ordy8;
  logic        ov8;
  logic [7:0]  od8;
  logic        ol8;
  logic        lr8;

`ifdef REG_READOUT_PARITY_EN
  logic        op;
  logic        op8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_readout #(.WIDTH(32), .SLICE(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (lv),
    .load_ready (lr),
    .load_data  (ld),
    .out_valid  (ov),
    .out_ready  (ordy),
    .out_data   (od),
    .out_last   (ol)
`ifdef REG_READOUT_PARITY_EN
    ,
    .out_parity (op)
`endif
  );

  reg_readout #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .load_valid (lv8),
    .load_ready (lr8),
    .load_data  (ld8),
    .out_valid  (ov8),
    .out_ready  (ordy8),
    .out_data   (od8),
    .out_last   (ol8)
`ifdef REG_READOUT_PARITY_EN
    ,
    .out_parity (op8)
`endif
  );

  typedef struct {
    logic        rst;
    logic        lv;
    logic [31:0] ld;
    logic        ordy;
    logic        ov;
    logic [7:0]  od;
    logic        ol;
    logic        lr;
  } vec_t;

  localparam int NV = 38;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, then sample.
  task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic rd);
    @(negedge clk);
    rst  = r;
    lv   = v;
    ld   = d;
    ordy = rd;
    #1;
  endtask

  task automatic drive8(input logic v, input logic [7:0] d, input logic rd);
    @(negedge clk);
    lv8   = v;
    ld8   = d;
    ordy8 = rd;
    #1;
  endtask

  initial begin
    //            rst  lv   ld            ordy   ov   od     ol   lr
    tbl[0]  = '{1'b0,1'b0,32'h0,        1'b0, 1'b0,8'h00,1'b0,1'b1};
    // basic readout
    tbl[1]  = '{1'b0,1'b1,32'hDDCCBBAA, 1'b1, 1'b0,8'h00,1'b0,1'b1};
    tbl[2]  = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'hAA,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'hBB,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'hCC,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'hDD,1'b1,1'b1};
    tbl[6]  = '{1'b0,1'b0,32'h0,        1'b1, 1'b0,8'h00,1'b0,1'b1};
    // backpressure
    tbl[7]  = '{1'b0,1'b1,32'h44332211, 1'b1, 1'b0,8'h00,1'b0,1'b1};
    tbl[8]  = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'h11,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b1,32'h99999999, 1'b0, 1'b1,8'h22,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b0,32'h0,        1'b0, 1'b1,8'h22,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b0,32'h0,        1'b0, 1'b1,8'h22,1'b0,1'b0};
    tbl[12] = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'h22,1'b0,1'b0};
    tbl[13] = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'h33,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b0,32'h0,        1'b0, 1'b1,8'h44,1'b1,1'b0};
    tbl[15] = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'h44,1'b1,1'b1};
    tbl[16] = '{1'b0,1'b0,32'h0,        1'b1, 1'b0,8'h00,1'b0,1'b1};
    // back-to-back words
    tbl[17] = '{1'b0,1'b1,32'h04030201, 1'b1, 1'b0,8'h00,1'b0,1'b1};
    tbl[18] = '{1'b0,1'b1,32'h08070605, 1'b1, 1'b1,8'h01,1'b0,1'b0};
    tbl[19] = '{1'b0,1'b1,32'h08070605, 1'b1, 1'b1,8'h02,1'b0,1'b0};
    tbl[20] = '{1'b0,1'b1,32'h08070605, 1'b1, 1'b1,8'h03,1'b0,1'b0};
    tbl[21] = '{1'b0,1'b1,32'h08070605, 1'b1, 1'b1,8'h04,1'b1,1'b1};
    tbl[22] = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'h05,1'b0,1'b0};
    tbl[23] = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'h06,1'b0,1'b0};
    tbl[24] = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'h07,1'b0,1'b0};
    tbl[25] = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'h08,1'b1,1'b1};
    tbl[26] = '{1'b0,1'b0,32'h0,        1'b1, 1'b0,8'h00,1'b0,1'b1};
    // reset mid-word, then a fresh word
    tbl[27] = '{1'b0,1'b1,32'h04030201, 1'b1, 1'b0,8'h00,1'b0,1'b1};
    tbl[28] = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'h01,1'b0,1'b0};
    tbl[29] = '{1'b1,1'b0,32'h0,        1'b1, 1'b1,8'h02,1'b0,1'b0};
    tbl[30] = '{1'b0,1'b0,32'h0,        1'b1, 1'b0,8'h00,1'b0,1'b1};
    tbl[31] = '{1'b0,1'b0,32'h0,        1'b1, 1'b0,8'h00,1'b0,1'b1};
    tbl[32] = '{1'b0,1'b1,32'hA0B0C0D0, 1'b1, 1'b0,8'h00,1'b0,1'b1};
    tbl[33] = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'hD0,1'b0,1'b0};
    tbl[34] = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'hC0,1'b0,1'b0};
    tbl[35] = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'hB0,1'b0,1'b0};
    tbl[36] = '{1'b0,1'b0,32'h0,        1'b1, 1'b1,8'hA0,1'b1,1'b1};
    tbl[37] = '{1'b0,1'b0,32'h0,        1'b1, 1'b0,8'h00,1'b0,1'b1};

    rst = 1'b1; lv = 1'b0; ld = '0; ordy = 1'b0;
    lv8 = 1'b0; ld8 = '0; ordy8 = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].lv, tbl[i].ld, tbl[i].ordy);
      chk($sformatf("row%0d out_valid", i),  32'(ov), 32'(tbl[i].ov));
      chk($sformatf("row%0d out_data", i),   32'(od), 32'(tbl[i].od));
      chk($sformatf("row%0d out_last", i),   32'(ol), 32'(tbl[i].ol));
      chk($sformatf("row%0d load_ready", i), 32'(lr), 32'(tbl[i].lr));
    end

    // Single-beat configuration: every beat is last, back-to-back reload.
    drive8(1'b1, 8'h81, 1'b1);
    chk("w8 idle out_valid", 32'(ov8), 32'd0);
    chk("w8 idle load_ready", 32'(lr8), 32'd1);
    drive8(1'b1, 8'h5B, 1'b1);
    chk("w8 beat0 out_valid", 32'(ov8), 32'd1);
    chk("w8 beat0 out_data", 32'(od8), 32'h81);
    chk("w8 beat0 out_last", 32'(ol8), 32'd1);
    chk("w8 beat0 load_ready", 32'(lr8), 32'd1);
`ifdef REG_READOUT_PARITY_EN
    chk("w8 beat0 parity", 32'(op8), 32'd0);
`endif
    drive8(1'b0, 8'h00, 1'b0);
    chk("w8 beat1 out_data", 32'(od8), 32'h5B);
    chk("w8 beat1 out_last", 32'(ol8), 32'd1);
    chk("w8 stall load_ready", 32'(lr8), 32'd0);
`ifdef REG_READOUT_PARITY_EN
    chk("w8 beat1 parity", 32'(op8), 32'd1);
`endif
    drive8(1'b0, 8'h00, 1'b1);
    chk("w8 held out_data", 32'(od8), 32'h5B);
    drive8(1'b0, 8'h00, 1'b1);
    chk("w8 drained out_valid", 32'(ov8), 32'd0);
    chk("w8 drained out_data", 32'(od8), 32'd0);

`ifdef REG_READOUT_PARITY_EN
    // Parity beats for 0x000007FF: FF->0, 07->1, 00->0, 00->0.
    drive(1'b0, 1'b1, 32'h000007FF, 1'b1);
    chk("par idle", 32'(op), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("par beat0", 32'(op), 32'd0);
    chk("par beat0 data", 32'(od), 32'hFF);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("par beat1", 32'(op), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("par beat2", 32'(op), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("par beat3", 32'(op), 32'd0);
    chk("par beat3 last", 32'(ol), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("par after", 32'(op), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
